// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with ACK check
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          c_s1_q, c_s2_q, c_prev_q;
    logic          d_s1_q, d_s2_q;
    logic [8:0]    sh_q, sh_d;
    logic [3:0]    n_q, n_d;
    logic [IW-1:0] ih_q, ih_d;
    logic [TW-1:0] to_q, to_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall;
    logic          ih_last;

    // Bus idles high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_s1_q   <= 1'b1;
            c_s2_q   <= 1'b1;
            c_prev_q <= 1'b1;
            d_s1_q   <= 1'b1;
            d_s2_q   <= 1'b1;
        end else begin
            c_s1_q   <= ps2c_in;
            c_s2_q   <= c_s1_q;
            c_prev_q <= c_s2_q;
            d_s1_q   <= ps2d_in;
            d_s2_q   <= d_s1_q;
        end
    end

    assign fall    = c_prev_q & ~c_s2_q;
    assign ih_last = (ih_q == IW'(INHIBIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            ih_q    <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            ih_q    <= ih_d;
            to_q    <= to_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        n_d     = n_q;
        ih_d    = ih_q;
        to_d    = to_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q != S_IDLE && state_q != S_INHIBIT) begin
            to_d = fall ? TW'(1) : to_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    sh_d    = {~^tx_data, tx_data};
                    ih_d    = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (ih_last) begin
                    n_d     = '0;
                    to_d    = '0;
                    state_d = S_START;
                end else begin
                    ih_d = ih_q + 1'b1;
                end
            end
            S_START: begin
                if (fall) begin
                    n_d     = 4'd1;
                    state_d = S_DATA;
                end
            end
            // sh_q[0] is always the bit on the wire; after eight shifts it holds parity.
            S_DATA: begin
                if (fall) begin
                    n_d = n_q + 1'b1;
                    if (n_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        sh_d = {1'b1, sh_q[8:1]};
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    n_d = n_q + 1'b1;
                    if (d_s2_q) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (c_s2_q && d_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && state_q != S_INHIBIT && !fall &&
            to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            done_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign ps2c_oe = (state_q == S_INHIBIT);
    assign ps2d_oe = ((state_q == S_INHIBIT) && ih_last) ||
                     (state_q == S_START) ||
                     ((state_q == S_DATA) && !sh_q[0]);

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable, and checks the device acknowledge. It shares the open-drain ps2c/ps2d lines with the existing keyboard receiver. The top level ties each line low when its _oe output is 1 and releases it otherwise. The receiver must ignore the bus while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the clock line is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles between device clock falling edges, and from START to the first edge (15 ms at 50 MHz).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
tx_data  in  8  byte to send; sampled on the tx_start cycle
tx_start  in  1  single-cycle request
busy  out  1  high from the cycle after an accepted tx_start until the return to IDLE
done  out  1  one-cycle pulse: byte sent and ACK received
err  out  1  one-cycle pulse: NACK or timeout
ps2c_in  in  1  raw PS/2 clock line
ps2d_in  in  1  raw PS/2 data line
ps2c_oe  out  1  1 = pull clock line low
ps2d_oe  out  1  1 = pull data line low

Behaviour:
- Reset (async, rst=0): state IDLE; busy, done, err, ps2c_oe and ps2d_oe all 0. Lines are released immediately, including mid-transfer.
- Inputs: ps2c_in and ps2d_in pass through 2-flop synchronisers. fall = registered synced clock 1 followed by synced clock 0. Edge detection adds 2-3 clk of latency, which is negligible against the ~10 kHz PS/2 clock.
- Accept: tx_start in IDLE latches tx_data into a shift register and computes parity = ~^tx_data (odd parity). tx_start outside IDLE is ignored; the latched byte is unchanged.
- States and transitions:
  - IDLE: ps2c_oe=0, ps2d_oe=0.
  - INHIBIT: ps2c_oe=1 for exactly INHIBIT_CYCLES clk. ps2d_oe=1 is asserted in the last cycle of INHIBIT.
  - START: ps2c_oe=0, ps2d_oe=1 (start bit = 0). Bit counter n=0; timeout counter cleared.
  - On each fall in START/DATA: n increments, and the line drives the next bit.
    - n=1..8: ps2d_oe = ~bit[n-1], LSB first.
    - n=9: ps2d_oe = ~parity.
    - n=10: ps2d_oe=0 (stop bit; line released). Go to ACK.
  - ACK: on the next fall (n=11), sample synced data. 0 = ACK, go to WAIT_IDLE; 1 = NACK, pulse err, go to IDLE.
  - WAIT_IDLE: wait for synced clock=1 and data=1 simultaneously, then pulse done and go to IDLE.
- Timeout: in START, DATA, ACK and WAIT_IDLE, a counter resets on every fall and increments otherwise. On reaching TIMEOUT_CYCLES: release both lines, pulse err, go to IDLE.
- busy = (state != IDLE). done and err are never asserted in the same cycle. busy drops in the same cycle that done/err pulses.
- A new tx_start accepted in the cycle after done/err starts a fresh transfer normally.

Test Plan:
- INHIBIT_CYCLES=8; tx_start with tx_data=0xED -> ps2c_oe high exactly 8 clk. A device model clocking at ~1/40 clk sees frame 0,1,0,1,1,0,1,1,1,parity=1,stop=1. Device ACKs low -> done pulses once and busy falls.
- tx_data=0xF4 -> device-sampled bits 0,0,0,1,0,1,1,1,1, parity 0, stop 1; done pulse.
- Device leaves data high at the 11th falling edge (NACK) -> err pulses 1 cycle, done stays 0, both _oe 0.
- Device stops clocking after the 5th falling edge, TIMEOUT_CYCLES=100 -> err exactly 100 clk after the last fall; lines released.
- tx_start reasserted with 0x00 mid-transfer of 0xED -> ignored; the 0xED frame is unchanged.
- rst=0 asserted during DATA -> ps2c_oe, ps2d_oe, busy drop asynchronously. After rst=1, a new 0xF4 transfer completes with done.
